// File: rtl/uart_recv_if.sv
// ============================================================================
//  Module   : uart_recv_if
//  Brief    : Serial input and parallel byte/strobe outputs of uart_recv.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_recv_if;
    logic       RXD;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       IDLE;

    // Receiver side
    modport slave (
        input  RXD,
        output DATA,
        output DATA_READY,
        output FRAME_ERR,
        output IDLE
    );

    // Line driver / byte consumer side
    modport master (
        output RXD,
        input  DATA,
        input  DATA_READY,
        input  FRAME_ERR,
        input  IDLE
    );
endinterface

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
//  Module   : uart_recv
//  Brief    : 8N1 UART receiver, centre sampling, one-cycle byte/error strobes.
//             Optional macro UART_RECV_MAJORITY_EN: 2-of-3 majority per bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_recv #(
    parameter int BIT_CYCLES = 26
) (
    input  logic   CLK,
    input  logic   RST,
    uart_recv_if.slave bus
);

    localparam int c_half = BIT_CYCLES / 2;
    localparam int c_cw   = $clog2(BIT_CYCLES);

`ifdef UART_RECV_MAJORITY_EN
    // Decision taken one cycle after the centre so all three samples exist
    localparam int c_start_last = c_half;
`else
    localparam int c_start_last = c_half - 1;
`endif

    localparam logic [c_cw-1:0] c_start_end = c_cw'(c_start_last);
    localparam logic [c_cw-1:0] c_bit_end   = c_cw'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          r_state, w_state_n;
    logic [c_cw-1:0] r_cnt, w_cnt_n;
    logic [2:0]      r_bitidx, w_bitidx_n;
    logic [7:0]      r_shift, w_shift_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_ready, w_ready_n;
    logic            r_ferr, w_ferr_n;

    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic            w_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.RXD};
        end
    end

    assign w_rx_s = r_sync[1];

`ifdef UART_RECV_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_ready  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_bitidx <= w_bitidx_n;
            r_shift  <= w_shift_n;
            r_data   <= w_data_n;
            r_ready  <= w_ready_n;
            r_ferr   <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_bitidx_n = r_bitidx;
        w_shift_n  = r_shift;
        w_data_n   = r_data;
        w_ready_n  = 1'b0;
        w_ferr_n   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = S_START;
                    w_cnt_n   = '0;
                end
            end

            S_START: begin
                if (r_cnt == c_start_end) begin
                    if (w_bit) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n  = S_DATA;
                        w_cnt_n    = '0;
                        w_bitidx_n = '0;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == c_bit_end) begin
                    w_cnt_n             = '0;
                    w_shift_n[r_bitidx] = w_bit;
                    w_bitidx_n          = r_bitidx + 1'b1;
                    if (r_bitidx == 3'd7) begin
                        w_state_n = S_STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (r_cnt == c_bit_end) begin
                    w_cnt_n = '0;
                    if (w_bit) begin
                        w_data_n  = r_shift;
                        w_ready_n = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = S_BREAK;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end

            // Held-low line must go high before a new start bit is accepted
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.DATA       = r_data;
    assign bus.DATA_READY = r_ready;
    assign bus.FRAME_ERR  = r_ferr;
    assign bus.IDLE       = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
// ============================================================================
//  Module   : tb_uart_recv
//  Brief    : Scoreboard bench for uart_recv driven by a behavioural 8N1 sender.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_recv;

    localparam int BIT  = 26;
    localparam int HALF = BIT / 2;
`ifdef UART_RECV_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Stop sample edge measured from the first edge that sees RXD low
    localparam int LAT = 2 + HALF + 9 * BIT + MAJ;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         start;
        bit         chk_gap;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    uart_recv_if bus ();

    uart_recv #(.BIT_CYCLES(BIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t       q[$];
    exp_t       m;
    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         strobes    = 0;
    int         last_ready = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame
    always @(negedge CLK) begin
        if (!RST && (bus.DATA_READY || bus.FRAME_ERR)) begin
            strobes++;
            chk("strobe_exclusive", int'(bus.DATA_READY & bus.FRAME_ERR), 0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                m = q.pop_front();
                chk("strobe_kind_ferr", int'(bus.FRAME_ERR), int'(m.err));
                chk("strobe_data", int'(bus.DATA), int'(m.data));
                chk("strobe_latency", cyc - m.start, LAT);
                if (bus.DATA_READY) begin
                    chk("idle_with_ready", int'(bus.IDLE), 1);
                    if (m.chk_gap) chk("ready_spacing", cyc - last_ready, 10 * BIT);
                    last_ready = cyc;
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.RXD = v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input int nstop,
                              input bit glitch, input bit gap);
        exp_t e;
        e.err     = !stopv;
        e.data    = stopv ? b : model_data;
        e.start   = cyc + 1;
        e.chk_gap = gap;
        if (stopv) model_data = b;
        q.push_back(e);
        hold(1'b0, BIT);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < BIT; i++) begin
                bus.RXD = (glitch && i == HALF) ? ~b[k] : b[k];
                @(posedge CLK);
                #1;
            end
        end
        hold(stopv, BIT * nstop);
    endtask

    int         n_idle_low;
    int         s_before;
    logic [7:0] rb;

    initial begin
        bus.RXD = 1'b1;
        RST     = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_data", int'(bus.DATA), 0);
        chk("rst_ready", int'(bus.DATA_READY), 0);
        chk("rst_ferr", int'(bus.FRAME_ERR), 0);
        chk("rst_idle", int'(bus.IDLE), 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        hold(1'b1, 5);

        // Single frame 0xA5
        send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b0);
        hold(1'b1, 2 * BIT);
        chk("a5_idle", int'(bus.IDLE), 1);
        chk("a5_data", int'(bus.DATA), 8'hA5);

        // Back-to-back frames with one stop bit
        send_frame(8'h00, 1'b1, 1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b1);
        hold(1'b1, 2 * BIT);

        // Short start glitch
        s_before   = strobes;
        n_idle_low = 0;
        fork
            begin
                hold(1'b0, 5);
                hold(1'b1, 60);
            end
            begin
                repeat (60) begin
                    @(negedge CLK);
                    if (!bus.IDLE) n_idle_low++;
                end
            end
        join
        chk("glitch_idle_low", n_idle_low, HALF + MAJ);
        chk("glitch_no_strobe", strobes - s_before, 0);
        chk("glitch_data", int'(bus.DATA), int'(model_data));
        chk("glitch_idle_end", int'(bus.IDLE), 1);

        // Framing error followed by a held-low line
        s_before = strobes;
        send_frame(8'h3C, 1'b0, 1, 1'b0, 1'b0);
        hold(1'b0, 500);
        chk("break_one_strobe", strobes - s_before, 1);
        chk("break_data_kept", int'(bus.DATA), 8'h5A);
        hold(1'b1, 2 * BIT);
        send_frame(8'h81, 1'b1, 1, 1'b0, 1'b0);
        hold(1'b1, 2 * BIT);

        // Reset during bit 4 of a 0x55 frame
        s_before = strobes;
        rb       = 8'h55;
        hold(1'b0, BIT);
        for (int k = 0; k < 4; k++) hold(rb[k], BIT);
        hold(rb[4], HALF);
        chk("mid_frame_busy", int'(bus.IDLE), 0);
        RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_mid_data", int'(bus.DATA), 0);
            chk("rst_mid_idle", int'(bus.IDLE), 1);
            @(posedge CLK);
            #1;
        end
        RST        = 1'b0;
        model_data = 8'h00;
        hold(1'b1, 11 * BIT);
        chk("rst_no_strobe", strobes - s_before, 0);
        send_frame(8'h7E, 1'b1, 1, 1'b0, 1'b0);
        hold(1'b1, 2 * BIT);

        // Random loopback traffic (centre glitches when majority voting is built in)
        for (int n = 0; n < 256; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(1, 2)),
                       MAJ != 0, 1'b0);
            hold(1'b1, int'($urandom_range(0, 6)));
        end

        for (int t = 0; t < 2000 && q.size() != 0; t++) @(posedge CLK);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
